cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 15 +
 rtl/cdb_arbiter_rr_pick2.sv | 43 ++++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter.
// Holds the CDB slot count and the cdb_entry_t result record.
package cdb_arbiter_pkg;

  localparam int CDB_SLOTS     = 2;
  localparam int CDB_XLEN      = 32;
  localparam int CDB_TAG_WIDTH = 6;

  typedef struct packed {
    logic                     valid;
    logic [CDB_TAG_WIDTH-1:0] tag;
    logic [CDB_XLEN-1:0]      data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Rotated two-winner priority pick: scans ptr, ptr+1, ... mod N.
// Ports: req (request vector), ptr (scan start),
//   first_valid/first_idx, second_valid/second_idx (winners).
module rr_pick2
  import cdb_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             first_valid,
  output logic [PTR_W-1:0] first_idx,
  output logic             second_valid,
  output logic [PTR_W-1:0] second_idx
);

  always_comb begin
    int j;
    logic [PTR_W-1:0] jj;
    j = 0;
    jj = '0;
    first_valid = 1'b0;
    first_idx = '0;
    second_valid = 1'b0;
    second_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = PTR_W'(j);
      if (req[jj]) begin
        if (!first_valid) begin
          first_valid = 1'b1;
          first_idx = jj;
        end else if (!second_valid) begin
          second_valid = 1'b1;
          second_idx = jj;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-slot common data bus arbiter, round-robin over REQ_CNT units.
// Ports: clock, reset (sync, active high), clear (flush),
//   req_valid/req_data/req_tag in, req_grant out (combinational),
//   bus_valid/bus_data/bus_tag out (registered, latency 1).
// Macro CDB_ARB_BRANCH_PRIO_EN: requester 0 always owns slot 0.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REQ_CNT   = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic [REQ_CNT-1:0]                   req_valid,
  input  logic [REQ_CNT-1:0][XLEN-1:0]         req_data,
  input  logic [REQ_CNT-1:0][TAG_WIDTH-1:0]    req_tag,
  output logic [REQ_CNT-1:0]                   req_grant,
  output logic [CDB_SLOTS-1:0]                 bus_valid,
  output logic [CDB_SLOTS-1:0][XLEN-1:0]       bus_data,
  output logic [CDB_SLOTS-1:0][TAG_WIDTH-1:0]  bus_tag
);

  localparam int PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [REQ_CNT-1:0] pick_req;
  logic               prio;
  logic               f_v;
  logic               s_v;
  logic [PTR_W-1:0]   f_idx;
  logic [PTR_W-1:0]   s_idx;
  logic               s0_v;
  logic               s1_v;
  logic [PTR_W-1:0]   s0_idx;
  logic [PTR_W-1:0]   s1_idx;
  logic               adv_v;
  logic [PTR_W-1:0]   adv_idx;

`ifdef CDB_ARB_BRANCH_PRIO_EN
  // Branch unit bypasses the rotation; the others share what is left.
  assign prio     = req_valid[0];
  assign pick_req = {req_valid[REQ_CNT-1:1], 1'b0};
`else
  assign prio     = 1'b0;
  assign pick_req = req_valid;
`endif

  rr_pick2 #(
    .N     (REQ_CNT),
    .PTR_W (PTR_W)
  ) u_pick (
    .req          (pick_req),
    .ptr          (rr_ptr),
    .first_valid  (f_v),
    .first_idx    (f_idx),
    .second_valid (s_v),
    .second_idx   (s_idx)
  );

  always_comb begin
    s0_v = 1'b0;
    s0_idx = '0;
    s1_v = 1'b0;
    s1_idx = '0;
    adv_v = 1'b0;
    adv_idx = '0;
    if (!(reset || clear)) begin
      if (prio) begin
        // Slot 0 to requester 0; pointer moves only on slot 1 winner.
        s0_v = 1'b1;
        s1_v = f_v;
        s1_idx = f_idx;
        adv_v = f_v;
        adv_idx = f_idx;
      end else begin
        s0_v = f_v;
        s0_idx = f_idx;
        s1_v = s_v;
        s1_idx = s_idx;
        adv_v = f_v;
        adv_idx = s_v ? s_idx : f_idx;
      end
    end
  end

  always_comb begin
    req_grant = '0;
    if (s0_v) req_grant[s0_idx] = 1'b1;
    if (s1_v) req_grant[s1_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      bus_valid <= '0;
      bus_data <= '0;
      bus_tag <= '0;
    end else begin
      bus_valid <= {s1_v, s0_v};
      bus_data[0] <= s0_v ? req_data[s0_idx] : '0;
      bus_tag[0] <= s0_v ? req_tag[s0_idx] : '0;
      bus_data[1] <= s1_v ? req_data[s1_idx] : '0;
      bus_tag[1] <= s1_v ? req_tag[s1_idx] : '0;
      if (adv_v) begin
        if (adv_idx == PTR_W'(REQ_CNT - 1)) rr_ptr <= '0;
        else rr_ptr <= adv_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with a bus-result scoreboard.
// Grants checked mid-cycle; bus slots checked one cycle later.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct packed {
    cdb_entry_t s1;
    cdb_entry_t s0;
  } bus_exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              clear;
  logic [3:0]        req_valid;
  logic [3:0][31:0]  req_data;
  logic [3:0][5:0]   req_tag;
  logic [3:0]        req_grant;
  logic [1:0]        bus_valid;
  logic [1:0][31:0]  bus_data;
  logic [1:0][5:0]   bus_tag;

  int checks = 0;
  int errors = 0;
  bus_exp_t sb[$];

  cdb_arbiter #(
    .XLEN      (32),
    .REQ_CNT   (4),
    .TAG_WIDTH (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .req_grant (req_grant),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_tag   (bus_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic cdb_entry_t mk(input int s);
    cdb_entry_t r;
    r = '0;
    if (s >= 0) begin
      r.valid = 1'b1;
      r.tag = req_tag[s];
      r.data = req_data[s];
    end
    return r;
  endfunction

  task automatic randomize_payload();
    for (int i = 0; i < 4; i++) begin
      req_data[i] = $urandom;
      req_tag[i] = 6'($urandom_range(0, 63));
    end
  endtask

  // One cycle: expected grant and the requester expected in each slot.
  task automatic step(input logic [3:0] eg, input int s0,
                      input int s1, input string name);
    bus_exp_t e;
    @(negedge clock);
    checks++;
    if (req_grant !== eg) begin
      errors++;
      $display("FAIL %s grant: got %b expected %b", name, req_grant, eg);
    end
    e.s0 = mk(s0);
    e.s1 = mk(s1);
    sb.push_back(e);
    @(posedge clock);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (bus_valid !== {e.s1.valid, e.s0.valid}) begin
        errors++;
        $display("FAIL %s bus_valid: got %b expected %b", name,
                 bus_valid, {e.s1.valid, e.s0.valid});
      end
      checks++;
      if (bus_tag !== {e.s1.tag, e.s0.tag}) begin
        errors++;
        $display("FAIL %s bus_tag: got %h expected %h", name,
                 bus_tag, {e.s1.tag, e.s0.tag});
      end
      checks++;
      if (bus_data !== {e.s1.data, e.s0.data}) begin
        errors++;
        $display("FAIL %s bus_data: got %h expected %h", name,
                 bus_data, {e.s1.data, e.s0.data});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    req_valid = 4'b1111;
    randomize_payload();
    step(4'b0000, -1, -1, "reset_a");
    step(4'b0000, -1, -1, "reset_b");
    reset = 1'b0;
  endtask

  task automatic test_all_valid();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_data[i] = 32'hA000_0000 + i;
      req_tag[i] = 6'(8 + i);
    end
    step(4'b0011, 0, 1, "all_c0");
    step(4'b1100, 2, 3, "all_c1");
    step(4'b0011, 0, 1, "all_c2");
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    randomize_payload();
    req_tag[2] = 6'h15;
    req_data[2] = 32'hDEADBEEF;
    step(4'b0100, 2, -1, "single");
  endtask

  task automatic test_wrap();
    req_valid = 4'b1001;
    randomize_payload();
    step(4'b1001, 3, 0, "wrap");
    req_valid = 4'b1111;
    randomize_payload();
    step(4'b0110, 1, 2, "wrap_ptr1");
  endtask

  task automatic test_clear();
    req_valid = 4'b0110;
    randomize_payload();
    clear = 1'b1;
    step(4'b0000, -1, -1, "clear_on");
    clear = 1'b0;
    step(4'b0110, 1, 2, "clear_off");
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001;
    randomize_payload();
    step(4'b0001, 0, -1, "mid_grant");
    reset = 1'b1;
    req_valid = 4'b1111;
    step(4'b0000, -1, -1, "mid_reset");
    reset = 1'b0;
    randomize_payload();
    step(4'b0011, 0, 1, "mid_ptr0");
  endtask

  task automatic test_back_to_back();
    req_valid = 4'b0111;
    randomize_payload();
    step(4'b0101, 2, 0, "b2b_0");
    randomize_payload();
    step(4'b0110, 1, 2, "b2b_1");
    randomize_payload();
    step(4'b0011, 0, 1, "b2b_2");
    req_valid = 4'b0000;
    step(4'b0000, -1, -1, "b2b_idle");
  endtask

  task automatic test_branch_prio();
    req_valid = 4'b1111;
    randomize_payload();
    step(4'b0011, 0, 1, "prio_0");
    randomize_payload();
    step(4'b0101, 0, 2, "prio_1");
    randomize_payload();
    step(4'b1001, 0, 3, "prio_2");
    randomize_payload();
    step(4'b0011, 0, 1, "prio_3");
    randomize_payload();
    step(4'b0101, 0, 2, "prio_4");
    randomize_payload();
    step(4'b1001, 0, 3, "prio_5");
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_tag = '0;
    @(posedge clock);
    #1;
    test_reset();
`ifdef CDB_ARB_BRANCH_PRIO_EN
    test_branch_prio();
    test_single();
    test_clear();
`else
    test_all_valid();
    test_single();
    test_wrap();
    test_clear();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
